// File: rtl/fir_complex_decim.sv
// Time-multiplexed complex FIR with integer decimation: one complex MAC per cycle,
// reading paired I/Q samples from show-ahead FIFOs and writing paired real/imag results.
module fir_complex_decim #(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int NUM_TAPS    = 20,
    parameter int DECIMATION  = 1,
    parameter int FRAC_BITS   = 10,
    parameter logic signed [NUM_TAPS-1:0][COEFF_WIDTH-1:0] COEFF_REAL =
        {{(NUM_TAPS*COEFF_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS,
    parameter logic signed [NUM_TAPS-1:0][COEFF_WIDTH-1:0] COEFF_IMAG = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic                  i_empty,
    output logic                  i_rd_en,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  q_empty,
    output logic                  q_rd_en,
    output logic [DATA_WIDTH-1:0] real_out,
    output logic                  real_wr_en,
    input  logic                  real_full,
    output logic [DATA_WIDTH-1:0] imag_out,
    output logic                  imag_wr_en,
    input  logic                  imag_full
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int TAP_W      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int DEC_W      = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic signed [PROD_WIDTH-1:0] TRUNC_BIAS =
        (PROD_WIDTH'(1) << FRAC_BITS) - PROD_WIDTH'(1);

    typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  hist_r [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  hist_i [NUM_TAPS];
    logic [DEC_W-1:0]              dec_cnt;
    logic [TAP_W-1:0]              tap_idx;
    logic signed [DATA_WIDTH-1:0]  acc_r;
    logic signed [DATA_WIDTH-1:0]  acc_i;

    logic signed [COEFF_WIDTH-1:0] hr;
    logic signed [COEFF_WIDTH-1:0] hi;
    logic signed [DATA_WIDTH-1:0]  xr;
    logic signed [DATA_WIDTH-1:0]  xi;
    logic signed [PROD_WIDTH-1:0]  prod_r;
    logic signed [PROD_WIDTH-1:0]  prod_i;
    logic signed [DATA_WIDTH-1:0]  sum_r;
    logic signed [DATA_WIDTH-1:0]  sum_i;
    logic                          rd_fire;
    logic                          wr_fire;

    // Divide by 2^FRAC_BITS rounding toward zero: bias negatives before the arithmetic shift.
    function automatic logic signed [DATA_WIDTH-1:0] dequant(input logic signed [PROD_WIDTH-1:0] p);
        logic signed [PROD_WIDTH-1:0] biased;
        biased = p[PROD_WIDTH-1] ? (p + TRUNC_BIAS) : p;
        return DATA_WIDTH'(biased >>> FRAC_BITS);
    endfunction

    assign rd_fire    = (state == S_READ) && !i_empty && !q_empty;
    assign wr_fire    = (state == S_WRITE) && !real_full && !imag_full;
    assign i_rd_en    = rd_fire;
    assign q_rd_en    = rd_fire;
    assign real_wr_en = wr_fire;
    assign imag_wr_en = wr_fire;

    always_comb begin
        hr     = $signed(COEFF_REAL[tap_idx]);
        hi     = $signed(COEFF_IMAG[tap_idx]);
        xr     = hist_r[tap_idx];
        xi     = hist_i[tap_idx];
        prod_r = PROD_WIDTH'(hr) * PROD_WIDTH'(xr) - PROD_WIDTH'(hi) * PROD_WIDTH'(xi);
        prod_i = PROD_WIDTH'(hr) * PROD_WIDTH'(xi) + PROD_WIDTH'(hi) * PROD_WIDTH'(xr);
        sum_r  = acc_r + dequant(prod_r);
        sum_i  = acc_i + dequant(prod_i);
    end

    // The output words are loaded with the final sums on the last MAC step so they are
    // already valid during the write cycle and simply held while the output FIFOs are full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_READ;
            dec_cnt  <= '0;
            tap_idx  <= '0;
            acc_r    <= '0;
            acc_i    <= '0;
            real_out <= '0;
            imag_out <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                hist_r[k] <= '0;
                hist_i[k] <= '0;
            end
        end else begin
            case (state)
                S_READ: begin
                    if (rd_fire) begin
                        hist_r[0] <= i_in;
                        hist_i[0] <= q_in;
                        for (int k = 1; k < NUM_TAPS; k++) begin
                            hist_r[k] <= hist_r[k-1];
                            hist_i[k] <= hist_i[k-1];
                        end
                        if (dec_cnt == DEC_W'(DECIMATION - 1)) begin
                            dec_cnt <= '0;
                            acc_r   <= '0;
                            acc_i   <= '0;
                            tap_idx <= '0;
                            state   <= S_MAC;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc_r <= sum_r;
                    acc_i <= sum_i;
                    if (tap_idx == TAP_W'(NUM_TAPS - 1)) begin
                        real_out <= sum_r;
                        imag_out <= sum_i;
                        state    <= S_WRITE;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        state <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_complex_decim.sv
// Directed scoreboard bench for fir_complex_decim: five 4-tap instances with different
// coefficient/decimation settings share clock and reset, and are exercised one at a time.
module tb_fir_complex_decim;

    localparam int ND = 5;
    localparam logic [3:0][31:0] ID_TAPS   = {32'd0, 32'd0, 32'd0, 32'd1024};
    localparam logic [3:0][31:0] HALF_TAPS = {32'd0, 32'd0, 32'd0, 32'd512};
    localparam logic [3:0][31:0] TWO_TAPS  = {32'd0, 32'd0, 32'd1024, 32'd1024};
    localparam logic [3:0][31:0] NO_TAPS   = '0;
    localparam logic [3:0][31:0] CR [ND] = '{ID_TAPS, ID_TAPS, NO_TAPS, HALF_TAPS, TWO_TAPS};
    localparam logic [3:0][31:0] CI [ND] = '{NO_TAPS, NO_TAPS, ID_TAPS, NO_TAPS, NO_TAPS};

    typedef struct {
        int          d;
        logic [31:0] r;
        logic [31:0] i;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] i_in [ND];
    logic [31:0] q_in [ND];
    logic        i_empty [ND];
    logic        q_empty [ND];
    logic        i_rd_en [ND];
    logic        q_rd_en [ND];
    logic [31:0] real_out [ND];
    logic [31:0] imag_out [ND];
    logic        real_wr_en [ND];
    logic        imag_wr_en [ND];
    logic        real_full [ND];
    logic        imag_full [ND];

    exp_t sb[$];
    int   wr_count [ND];
    int   checks;
    int   failures;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fir_complex_decim #(
            .DATA_WIDTH (32),
            .COEFF_WIDTH(32),
            .NUM_TAPS   (4),
            .DECIMATION ((g == 1) ? 2 : 1),
            .FRAC_BITS  (10),
            .COEFF_REAL (CR[g]),
            .COEFF_IMAG (CI[g])
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .i_in      (i_in[g]),
            .i_empty   (i_empty[g]),
            .i_rd_en   (i_rd_en[g]),
            .q_in      (q_in[g]),
            .q_empty   (q_empty[g]),
            .q_rd_en   (q_rd_en[g]),
            .real_out  (real_out[g]),
            .real_wr_en(real_wr_en[g]),
            .real_full (real_full[g]),
            .imag_out  (imag_out[g]),
            .imag_wr_en(imag_wr_en[g]),
            .imag_full (imag_full[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic void push_exp(input int d, input logic [31:0] r, input logic [31:0] i);
        sb.push_back('{d, r, i});
    endfunction

    // Present one sample at the FIFO heads and hold it until the DUT pops it.
    task automatic apply_stimulus(input int d, input logic [31:0] ir, input logic [31:0] iq);
        int n = 0;
        @(negedge clock);
        i_in[d] = ir;
        q_in[d] = iq;
        i_empty[d] = 1'b0;
        q_empty[d] = 1'b0;
        #1;
        while (!(i_rd_en[d] && q_rd_en[d]) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_output("rd_timeout", 32'(n < 200), 32'd1);
        @(posedge clock);
        #1;
        i_empty[d] = 1'b1;
        q_empty[d] = 1'b1;
    endtask

    task automatic wait_write(input int d, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!real_wr_en[d] && n < 100);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (8) @(negedge clock);
        check_output(tag, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard side: every write strobe pops one expected pair; reads must be paired and never from an empty FIFO.
    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (!reset && (i_rd_en[d] || q_rd_en[d])) begin
                check_output($sformatf("rd_pair%0d", d),
                             32'({i_rd_en[d], q_rd_en[d], i_empty[d], q_empty[d]}), 32'b1100);
            end
            if (!reset && (real_wr_en[d] || imag_wr_en[d])) begin
                exp_t e;
                wr_count[d]++;
                check_output($sformatf("wr_pair%0d", d), 32'({real_wr_en[d], imag_wr_en[d]}), 32'b11);
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_write: dut %0d wrote (%0d,%0d) with no expectation queued",
                           d, $signed(real_out[d]), $signed(imag_out[d]));
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_output("wr_dut", 32'(d), 32'(e.d));
                    check_output($sformatf("real_out%0d", d), real_out[d], e.r);
                    check_output($sformatf("imag_out%0d", d), imag_out[d], e.i);
                end
            end
        end
    end

    initial begin
        int n;
        int cnt0;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        for (int d = 0; d < ND; d++) begin
            i_in[d]      = '0;
            q_in[d]      = '0;
            i_empty[d]   = 1'b1;
            q_empty[d]   = 1'b1;
            real_full[d] = 1'b0;
            imag_full[d] = 1'b0;
            wr_count[d]  = 0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("reset_real0", real_out[0], 32'd0);
        check_output("reset_imag0", imag_out[0], 32'd0);
        check_output("reset_real4", real_out[4], 32'd0);

        // identity taps, latency NUM_TAPS+1 from the read cycle
        push_exp(0, 100, -50);
        apply_stimulus(0, 100, -50);
        wait_write(0, n);
        check_output("t1_latency_a", 32'(n), 32'd5);
        push_exp(0, 7, 9);
        apply_stimulus(0, 7, 9);
        wait_write(0, n);
        check_output("t1_latency_b", 32'(n), 32'd5);
        drain("t1_drain");

        // decimation by two
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 0) push_exp(1, k, -k);
        end
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1, k, -k);
        end
        drain("t2_drain");
        check_output("t2_writes", 32'(wr_count[1]), 32'd4);

        // purely imaginary tap j: (3+5j)*j = -5+3j
        push_exp(2, -5, 3);
        apply_stimulus(2, 3, 5);
        drain("t3_drain");

        // half gain truncates toward zero
        push_exp(3, -1, 1);
        push_exp(3, 1, -1);
        apply_stimulus(3, -3, 3);
        apply_stimulus(3, 3, -3);
        drain("t4_half_drain");

        // two-tap impulse response
        push_exp(4, 10, 0);
        push_exp(4, 10, 0);
        push_exp(4, 0, 0);
        push_exp(4, 0, 0);
        apply_stimulus(4, 10, 0);
        apply_stimulus(4, 0, 0);
        apply_stimulus(4, 0, 0);
        apply_stimulus(4, 0, 0);
        drain("t4_impulse_drain");

        // backpressure: output stalls and no input is consumed meanwhile
        real_full[0] = 1'b1;
        push_exp(0, 11, 22);
        apply_stimulus(0, 11, 22);
        cnt0 = wr_count[0];
        repeat (5) @(negedge clock);
        i_in[0] = 33;
        q_in[0] = 44;
        i_empty[0] = 1'b0;
        q_empty[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_output("t5_wr_stall", 32'(real_wr_en[0] | imag_wr_en[0]), 32'd0);
            check_output("t5_rd_stall", 32'(i_rd_en[0] | q_rd_en[0]), 32'd0);
        end
        real_full[0] = 1'b0;
        push_exp(0, 33, 44);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!i_rd_en[0] && n < 50);
        check_output("t5_resume_rd", 32'(i_rd_en[0]), 32'd1);
        check_output("t5_one_write", 32'(wr_count[0] - cnt0), 32'd1);
        @(posedge clock);
        #1;
        i_empty[0] = 1'b1;
        q_empty[0] = 1'b1;
        wait_write(0, n);
        check_output("t5_latency", 32'(n), 32'd5);
        drain("t5_drain");
        check_output("t5_total_writes", 32'(wr_count[0] - cnt0), 32'd2);

        // reset in the middle of a MAC: partial result dropped, history cleared
        push_exp(4, 9, 0);
        apply_stimulus(4, 9, 0);
        drain("t6_pre_drain");
        cnt0 = wr_count[0];
        apply_stimulus(0, 77, 88);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_output("t6_reset_real", real_out[0], 32'd0);
        check_output("t6_reset_imag", imag_out[0], 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check_output("t6_no_write", 32'(wr_count[0] - cnt0), 32'd0);
        push_exp(4, 5, 0);
        apply_stimulus(4, 5, 0);
        drain("t6_hist4_drain");
        push_exp(0, 5, 0);
        apply_stimulus(0, 5, 0);
        drain("t6_post_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
